// File: rtl/hk_wb_byte_bridge_if.sv
// Wishbone classic slave-side bundle between the management core and the byte bridge.
interface hk_wb_byte_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/hk_wb_byte_bridge.sv
// Wishbone responder that splits each 32-bit access into four fixed-latency
// byte accesses on the housekeeping register bus.
module hk_wb_byte_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h2610_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_0000,
  parameter int unsigned AW       = 8
) (
  input  logic               core_clk,
  input  logic               core_rstn,
  hk_wb_byte_bridge_if.slave wb,
  output logic [AW-1:0]      reg_addr_o,
  output logic [7:0]         reg_wdata_o,
  output logic               reg_wen_o,
  output logic               reg_ren_o,
  input  logic [7:0]         reg_rdata_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, TAIL, ACK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-3:0] adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [31:0]   dat_q, dat_d;
  logic [23:0]   rbuf_q, rbuf_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;

  logic       req_live;
  logic       win_hit;
  logic [1:0] idx_nxt;
  logic [1:0] lane_prev;
  logic [7:0] rbyte;

  assign req_live  = wb.wb_cyc_i & wb.wb_stb_i;
  assign win_hit   = (wb.wb_adr_i & ADR_MASK) == BASE_ADR;
  assign idx_nxt   = idx_q + 2'd1;
  // The byte arriving now belongs to the lane strobed in the previous cycle;
  // idx wraps to 0 on entering TAIL so this also points at lane 3 there.
  assign lane_prev = idx_q - 2'd1;
  assign rbyte     = sel_q[lane_prev] ? reg_rdata_i : 8'h00;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_d   = dat_q;
    rbuf_d  = rbuf_q;
    rdat_d  = rdat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_live && win_hit) begin
          state_d = XFER;
          idx_d   = 2'd0;
          adr_d   = wb.wb_adr_i[AW-1:2];
          sel_d   = wb.wb_sel_i;
          we_d    = wb.wb_we_i;
          dat_d   = wb.wb_dat_i;
          addr_d  = {wb.wb_adr_i[AW-1:2], 2'b00};
          wdata_d = wb.wb_dat_i[7:0];
          wen_d   = wb.wb_we_i & wb.wb_sel_i[0];
          ren_d   = ~wb.wb_we_i & wb.wb_sel_i[0];
        end
      end
      XFER: begin
        if (!req_live) begin
          state_d = IDLE;
        end else begin
          if (!we_q) begin
            case (idx_q)
              2'd1:    rbuf_d[7:0]   = rbyte;
              2'd2:    rbuf_d[15:8]  = rbyte;
              2'd3:    rbuf_d[23:16] = rbyte;
              default: rbuf_d        = rbuf_q;
            endcase
          end
          idx_d = idx_nxt;
          if (idx_q == 2'd3) begin
            state_d = we_q ? ACK : TAIL;
          end else begin
            addr_d  = {adr_q, idx_nxt};
            wdata_d = dat_q[{idx_nxt, 3'b000} +: 8];
            wen_d   = we_q & sel_q[idx_nxt];
            ren_d   = ~we_q & sel_q[idx_nxt];
          end
        end
      end
      TAIL: begin
        if (!req_live) begin
          state_d = IDLE;
        end else begin
          rdat_d  = {rbyte, rbuf_q};
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      adr_q   <= '0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      dat_q   <= 32'h0;
      rbuf_q  <= 24'h0;
      rdat_q  <= 32'h0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      rbuf_q  <= rbuf_d;
      rdat_q  <= rdat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
    end
  end

  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wen_o   = wen_q;
  assign reg_ren_o   = ren_q;
  assign busy_o      = state_q != IDLE;
  assign wb.wb_ack_o = state_q == ACK;
  assign wb.wb_dat_o = rdat_q;

endmodule

// File: tb/tb_hk_wb_byte_bridge.sv
// Directed and randomized checks of the Wishbone byte bridge against a
// transaction-level model: per-cycle strobe schedule, byte memory and read data.
module tb_hk_wb_byte_bridge;
  localparam logic [31:0] BASE = 32'h2610_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic       core_clk  = 1'b0;
  logic       core_rstn = 1'b0;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wen, reg_ren, busy;

  hk_wb_byte_bridge_if bus();

  hk_wb_byte_bridge #(.BASE_ADR(BASE), .ADR_MASK(MASK), .AW(8)) dut (
    .core_clk    (core_clk),
    .core_rstn   (core_rstn),
    .wb          (bus),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_wen_o   (reg_wen),
    .reg_ren_o   (reg_ren),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy)
  );

  always #5 core_clk = ~core_clk;

  // Byte-register device: returns data the cycle after a read strobe, noise otherwise.
  logic [7:0] devmem [256];
  logic       dev_init = 1'b1;
  always @(posedge core_clk) begin
    if (dev_init) begin
      for (int i = 0; i < 256; i++) devmem[i] <= 8'(i) ^ 8'h5A;
    end else if (reg_wen) begin
      devmem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_ren ? devmem[reg_addr] : 8'($urandom);
  end

  logic [7:0]  shadow [256];
  logic [31:0] last_rd = 32'h0;
  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, reg_wen, reg_ren, bus.wb_ack_o, busy};
  endfunction

  task automatic idle_cycles(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge core_clk);
      chk("idle_flags", c, flags(), 32'd0);
      chk("idle_dat", c, bus.wb_dat_o, last_rd);
    end
  endtask

  // One bus access; abort_c drops cyc or stb in that cycle, rst_c pulls reset in that cycle.
  task automatic xfer(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, input int abort_c, input int rst_c);
    logic [7:0]  radr;
    logic [31:0] exp_rd;
    logic [3:0]  exp_f;
    logic        sel_now;
    int          ack_c, last_c, ncyc, lane;
    bit          stop;
    radr   = {adr[7:2], 2'b00};
    exp_rd = 32'h0;
    for (int i = 0; i < 4; i++)
      if (sel[i] && !we) exp_rd[8*i +: 8] = shadow[radr + 8'(i)];
    ack_c  = (abort_c != 0 || rst_c != 0) ? 0 : (we ? 5 : 6);
    last_c = (abort_c != 0 && abort_c < 4) ? abort_c : 4;
    ncyc   = (abort_c != 0) ? abort_c + 2 : ((rst_c != 0) ? rst_c : ack_c);
    txn++;
    $display("txn %0d: %s adr=%h sel=%b data=%h abort=%0d rst=%0d",
             txn, we ? "write" : "read ", adr, sel, we ? dat : exp_rd, abort_c, rst_c);

    @(negedge core_clk);
    chk("pre_idle", 0, flags(), 32'd0);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = we ? dat : $urandom;
    stop = 1'b0;

    for (int c = 1; c <= ncyc && !stop; c++) begin
      @(negedge core_clk);
      lane    = c - 1;
      sel_now = (c <= last_c) ? sel[lane[1:0]] : 1'b0;
      exp_f[3] = we & sel_now;
      exp_f[2] = ~we & sel_now;
      exp_f[1] = (c == ack_c);
      exp_f[0] = (abort_c != 0) ? (c <= abort_c) : ((rst_c != 0) ? 1'b1 : (c <= ack_c));
      chk("flags", c, flags(), {28'd0, exp_f});
      if (sel_now) begin
        chk("addr", c, 32'(reg_addr), 32'(radr | 8'(lane)));
        if (we) chk("wdata", c, 32'(reg_wdata), 32'(dat[8*lane +: 8]));
      end
      if (c == ack_c) begin
        chk("wb_dat", c, bus.wb_dat_o, we ? last_rd : exp_rd);
        if (!we) last_rd = exp_rd;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
      end
      if (c == abort_c) begin
        if ($urandom_range(0, 1) == 0) bus.wb_cyc_i = 1'b0;
        else                           bus.wb_stb_i = 1'b0;
      end
      if (c == rst_c) begin
        core_rstn = 1'b0;
        #1;
        chk("rst_flags", c, flags(), 32'd0);
        chk("rst_bus", c, 32'({reg_addr, reg_wdata}), 32'd0);
        chk("rst_dat", c, bus.wb_dat_o, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        last_rd = 32'h0;
        stop = 1'b1;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    if (we && rst_c == 0)
      for (int i = 0; i < last_c; i++)
        if (sel[i]) shadow[radr + 8'(i)] = dat[8*i +: 8];
  endtask

  task automatic nomatch(input logic [31:0] adr, input int n);
    txn++;
    $display("txn %0d: foreign adr=%h held %0d cycles", txn, adr, n);
    @(negedge core_clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'($urandom);
    bus.wb_sel_i = 4'hF;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = $urandom;
    for (int c = 1; c <= n; c++) begin
      @(negedge core_clk);
      chk("foreign_flags", c, flags(), 32'd0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  bit          r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  int          r_ab;

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'h0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;

    @(negedge core_clk);
    chk("reset_flags", 0, flags(), 32'd0);
    chk("reset_bus", 0, 32'({reg_addr, reg_wdata}), 32'd0);
    chk("reset_dat", 0, bus.wb_dat_o, 32'd0);
    repeat (2) @(negedge core_clk);
    dev_init  = 1'b0;
    core_rstn = 1'b1;

    // Directed cases
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, 0);
    chk("read_const", 6, bus.wb_dat_o, 32'h4948_4B4A);
    xfer(1'b1, 4'hF, BASE + 32'h10, 32'hA1B2_C3D4, 0, 0);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, 0);
    xfer(1'b1, 4'b0101, BASE + 32'h10, 32'h1122_3344, 0, 0);
    xfer(1'b0, 4'b1010, BASE + 32'h10, 32'h0, 0, 0);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, 0);
    nomatch(32'h3000_0000, 10);
    xfer(1'b1, 4'hF, BASE + 32'h20, 32'hDEAD_BEEF, 2, 0);
    xfer(1'b1, 4'hF, BASE + 32'h24, 32'h0BAD_F00D, 0, 0);
    xfer(1'b0, 4'hF, BASE + 32'h20, 32'h0, 0, 0);
    xfer(1'b0, 4'h0, BASE + 32'h20, 32'h0, 0, 0);
    xfer(1'b1, 4'h0, BASE + 32'h20, 32'hFFFF_FFFF, 0, 0);
    xfer(1'b0, 4'hF, BASE + 32'h20, 32'h0, 5, 0);
    xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, 3);
    repeat (2) @(negedge core_clk);
    core_rstn = 1'b1;
    idle_cycles(5);

    // Randomized traffic, including aborts and foreign addresses
    for (int k = 0; k < 60; k++) begin
      r_we  = 1'($urandom);
      r_sel = 4'($urandom);
      r_adr = BASE + (32'($urandom_range(0, 255)) << 8) + 32'($urandom_range(0, 31));
      r_ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, r_we ? 4 : 5) : 0;
      if ($urandom_range(0, 9) == 0) begin
        r_adr = $urandom;
        if ((r_adr & MASK) == BASE) r_adr = r_adr ^ 32'h8000_0000;
        nomatch(r_adr, 4);
      end else begin
        xfer(r_we, r_sel, r_adr, $urandom, r_ab, 0);
      end
    end
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
